// File: rtl/vh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vh_pkg
//  Description : Shared types and limits for the VlogHammer sweep checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package vh_pkg;

  // Deepest response latency the drain counter is sized for.
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vh_state_e;

endpackage
`default_nettype wire

// File: rtl/vh_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vh_delay_line
//  Description : Fixed-depth shift register carrying (valid, index) alongside
//                the response latency of the module under test. Depth 0 is a
//                plain wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module vh_delay_line
  import vh_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_shift
      logic [W-1:0] pipe_q [DEPTH];

      // Shift one stage per cycle; flush empties every stage at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else if (flush_i) begin
          for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign q_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vh_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : vh_sweep_checker
//  Description : Sweeps every input vector into a reference and a DUT
//                instance, compares their responses under a care mask after
//                a fixed latency and records pass/fail, a saturating mismatch
//                count and the first mismatch seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module vh_sweep_checker
  import vh_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 10,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  input  logic [OUT_W-1:0] care_mask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_valid,
  output logic [IN_W-1:0]  first_idx,
  output logic [OUT_W-1:0] first_ref,
  output logic [OUT_W-1:0] first_dut
);

  localparam logic [IN_W-1:0]  LAST_IDX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  // DRAIN lasts LAT cycles: the counter runs LAT-1 down to 0.
  localparam logic [3:0]       DRAIN_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  vh_state_e        state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [IN_W-1:0]  fidx_q, fidx_d;
  logic [OUT_W-1:0] fref_q, fref_d;
  logic [OUT_W-1:0] fdut_q, fdut_d;

  logic             w_abort;
  logic [IN_W:0]    w_dl_in, w_dl_out;
  logic             w_cmp_en;
  logic             w_mism;
  logic [OUT_W-1:0] w_diff;

  // Abort only has an effect once a sweep is running.
  assign w_abort = abort && (state_q != ST_IDLE);

  // Every cycle spent in SWEEP issues the current vector into the pipe.
  assign w_dl_in = {(state_q == ST_SWEEP), stim_q};

  vh_delay_line #(
    .DEPTH (LAT),
    .W     (IN_W + 1)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (w_abort),
    .d_i     (w_dl_in),
    .q_o     (w_dl_out)
  );

  // A compare landing on the abort edge is discarded.
  assign w_cmp_en = w_dl_out[IN_W] && !w_abort;
  assign w_diff   = (y_ref ^ y_dut) & care_mask;
  assign w_mism   = w_cmp_en && (|w_diff);

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SWEEP;
      ST_SWEEP: begin
        if (stim_q == LAST_IDX) begin
          if (LAT == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) state_d = ST_DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (w_abort) state_d = ST_IDLE;
  end

  // Stimulus counter and result bookkeeping.
  always_comb begin
    stim_d = stim_q;
    pass_d = pass_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fidx_d = fidx_q;
    fref_d = fref_q;
    fdut_d = fdut_q;

    if (state_q == ST_IDLE && start) begin
      stim_d = '0;
      pass_d = 1'b0;
      err_d  = '0;
      fv_d   = 1'b0;
      fidx_d = '0;
      fref_d = '0;
      fdut_d = '0;
    end else if (state_q == ST_SWEEP && stim_q != LAST_IDX && !w_abort) begin
      stim_d = stim_q + 1'b1;
    end

    if (w_mism) begin
      if (err_q != CNT_MAX) err_d = err_q + 1'b1;
      if (!fv_q) begin
        fv_d   = 1'b1;
        fidx_d = w_dl_out[IN_W-1:0];
        fref_d = y_ref;
        fdut_d = y_dut;
      end
    end

    // The final compare registers on the same edge that enters DONE.
    if (state_d == ST_DONE && state_q != ST_DONE) pass_d = (err_d == '0);
    if (w_abort) pass_d = 1'b0;
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= 4'd0;
      stim_q  <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fidx_q  <= '0;
      fref_q  <= '0;
      fdut_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stim_q  <= stim_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
      fref_q  <= fref_d;
      fdut_q  <= fdut_d;
    end
  end

  assign stim        = stim_q;
  assign busy        = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign err_cnt     = err_q;
  assign first_valid = fv_q;
  assign first_idx   = fidx_q;
  assign first_ref   = fref_q;
  assign first_dut   = fdut_q;

endmodule
`default_nettype wire

// File: tb/tb_vh_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vh_sweep_checker
//  Description : Bench for vh_sweep_checker. Instance 0 is IN_W=4/OUT_W=4,
//                LAT=2, CNT_W=16; instance 1 is IN_W=4/OUT_W=4, LAT=0,
//                CNT_W=3. Response tables emulate the tested module.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vh_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       start_s, abort_s;
  logic [1:0][3:0]  mask_s;
  logic [1:0][3:0]  yref, ydut;
  logic [1:0][3:0]  stim_o, fidx_o, fref_o, fdut_o;
  logic [1:0]       busy_o, done_o, pass_o, fv_o;
  logic [15:0]      err_a;
  logic [2:0]       err_b;
  logic [1:0][15:0] err_o;

  assign err_o[0] = err_a;
  assign err_o[1] = {13'd0, err_b};

  // Response tables indexed by vector: what the golden model and the
  // netlist would output for that input.
  logic [3:0] ref_tab [2][16];
  logic [3:0] dut_tab [2][16];
  int         lat_w   [2] = '{2, 0};
  int         cmax_w  [2] = '{65535, 7};

  // Instance 0 sees its responses two cycles after the vector.
  logic [3:0] h1, h2;
  always @(posedge clk) begin
    h1 <= stim_o[0];
    h2 <= h1;
  end
  assign yref[0] = ref_tab[0][h2];
  assign ydut[0] = dut_tab[0][h2];
  assign yref[1] = ref_tab[1][stim_o[1]];
  assign ydut[1] = dut_tab[1][stim_o[1]];

  vh_sweep_checker #(.IN_W(4), .OUT_W(4), .LAT(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .stim(stim_o[0]), .y_ref(yref[0]), .y_dut(ydut[0]), .care_mask(mask_s[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_cnt(err_a),
    .first_valid(fv_o[0]), .first_idx(fidx_o[0]), .first_ref(fref_o[0]),
    .first_dut(fdut_o[0])
  );

  vh_sweep_checker #(.IN_W(4), .OUT_W(4), .LAT(0), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .stim(stim_o[1]), .y_ref(yref[1]), .y_dut(ydut[1]), .care_mask(mask_s[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_cnt(err_b),
    .first_valid(fv_o[1]), .first_idx(fidx_o[1]), .first_ref(fref_o[1]),
    .first_dut(fdut_o[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int w);
    chk("rst_stim",  32'(stim_o[w]), 0);
    chk("rst_busy",  32'(busy_o[w]), 0);
    chk("rst_done",  32'(done_o[w]), 0);
    chk("rst_pass",  32'(pass_o[w]), 0);
    chk("rst_err",   32'(err_o[w]),  0);
    chk("rst_fv",    32'(fv_o[w]),   0);
    chk("rst_fidx",  32'(fidx_o[w]), 0);
    chk("rst_fref",  32'(fref_o[w]), 0);
    chk("rst_fdut",  32'(fdut_o[w]), 0);
  endtask

  // One sweep on instance w. abort_at < 0 means run to completion;
  // inj_start pulses start mid-sweep, which must be ignored.
  task automatic run(input int w, input int abort_at, input bit inj_start);
    int done_at, n_done, n_cmp, exp_err, exp_first;
    logic [3:0] exp_fref, exp_fdut;
    @(negedge clk);
    start_s[w] = 1'b1;
    @(posedge clk); #1;
    start_s[w] = 1'b0;
    done_at = -1;
    n_done  = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 0) chk("busy_rise", 32'(busy_o[w]), 1);
      if (c < 16 && abort_at < 0) chk("stim_seq", 32'(stim_o[w]), 32'(c));
      if (done_o[w]) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (abort_at < 0 && c == 15 + lat_w[w]) chk("busy_last", 32'(busy_o[w]), 1);
      if (abort_at < 0 && c == 16 + lat_w[w]) chk("busy_fall", 32'(busy_o[w]), 0);
      if (abort_at >= 0 && c == abort_at) begin
        chk("abort_busy", 32'(busy_o[w]), 0);
        chk("abort_pass", 32'(pass_o[w]), 0);
      end
      start_s[w] = inj_start && (c == 3);
      abort_s[w] = (c == abort_at - 1);
      @(posedge clk); #1;
    end
    abort_s[w] = 1'b0;

    // Vector i is judged at edge k+i+LAT+1; abort at edge k+a kills
    // every judgement at or after that edge.
    if (abort_at < 0) n_cmp = 16;
    else              n_cmp = (abort_at - lat_w[w] - 1 > 0) ? abort_at - lat_w[w] - 1 : 0;
    exp_err = 0; exp_first = -1; exp_fref = 4'd0; exp_fdut = 4'd0;
    for (int i = 0; i < n_cmp; i++) begin
      if (((ref_tab[w][i] ^ dut_tab[w][i]) & mask_s[w]) != 4'd0) begin
        if (exp_err < cmax_w[w]) exp_err++;
        if (exp_first < 0) begin
          exp_first = i;
          exp_fref  = ref_tab[w][i];
          exp_fdut  = dut_tab[w][i];
        end
      end
    end

    if (abort_at < 0) begin
      chk("done_time",  32'(done_at), 32'(16 + lat_w[w]));
      chk("done_count", 32'(n_done), 1);
      chk("pass",       32'(pass_o[w]), 32'(exp_err == 0));
    end else begin
      chk("abort_nodone", 32'(n_done), 0);
      chk("abort_pass2",  32'(pass_o[w]), 0);
    end
    chk("err_cnt",   32'(err_o[w]),  32'(exp_err));
    chk("first_v",   32'(fv_o[w]),   32'(exp_first >= 0));
    chk("first_idx", 32'(fidx_o[w]), (exp_first >= 0) ? 32'(exp_first) : 0);
    chk("first_ref", 32'(fref_o[w]), 32'(exp_fref));
    chk("first_dut", 32'(fdut_o[w]), 32'(exp_fdut));
  endtask

  task automatic set_identity(input int w);
    for (int i = 0; i < 16; i++) begin
      ref_tab[w][i] = 4'(i);
      dut_tab[w][i] = 4'(i);
    end
  endtask

  task automatic set_random(input int w);
    for (int i = 0; i < 16; i++) begin
      ref_tab[w][i] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        dut_tab[w][i] = ref_tab[w][i] ^ 4'($urandom_range(1, 15));
      else
        dut_tab[w][i] = ref_tab[w][i];
    end
    mask_s[w] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst_n   = 1'b0;
    start_s = '0;
    abort_s = '0;
    mask_s  = {4'hF, 4'hF};
    set_identity(0);
    set_identity(1);
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean sweep, plus an ignored start pulse mid-sweep.
    run(0, -1, 1'b1);

    // Single error at index 5 on bit 0.
    dut_tab[0][5] = 4'h4;
    run(0, -1, 1'b0);

    // Same error hidden by the care mask.
    mask_s[0] = 4'b1110;
    run(0, -1, 1'b0);
    mask_s[0] = 4'hF;

    // Saturation on the 3-bit counter, LAT=0.
    set_identity(1);
    for (int i = 0; i < 16; i++) dut_tab[1][i] = ~ref_tab[1][i];
    run(1, -1, 1'b0);

    // Abort at edge k+5 with errors on the first four vectors.
    set_identity(0);
    for (int i = 0; i < 4; i++) dut_tab[0][i] = ~ref_tab[0][i];
    run(0, 5, 1'b0);

    // Abort on the LAT=0 instance.
    run(1, 6, 1'b0);

    // Randomised sweeps on both instances.
    for (int r = 0; r < 6; r++) begin
      set_random(r % 2);
      run(r % 2, -1, 1'b0);
    end

    // Asynchronous reset in the middle of a LAT=0 sweep.
    set_identity(1);
    for (int i = 0; i < 16; i++) dut_tab[1][i] = ~ref_tab[1][i];
    mask_s[1] = 4'hF;
    @(negedge clk);
    start_s[1] = 1'b1;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(1);
    chk_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    set_identity(1);
    run(1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vh_sweep_checker.md
# vh_sweep_checker

Sequential stimulus-and-compare harness placed directly upstream and downstream of a VlogHammer expression-test module. It drives every input vector of a reference instance and a device-under-test (DUT) instance. Examples of such test modules are the `issue_*` cells, where one instance is the golden simulation model and the other is the synthesized netlist. It compares the two output buses under a care mask after a fixed latency. It reports the pass/fail result, a mismatch count and the first mismatch.

## Interface
- `IN_W`, 8: stimulus width; the sweep covers 2^IN_W vectors.
- `OUT_W`, 10: width of the compared output buses.
- `LAT`, 2: cycles from stimulus change to valid responses. Range 0..15; 0 means purely combinational.
- `CNT_W`, 16: width of the mismatch counter.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a sweep; sampled only in IDLE.
- `abort`  in  1: cancel the running sweep.
- `stim`  out  IN_W: vector driven to both instances.
- `y_ref`  in  OUT_W: reference response.
- `y_dut`  in  OUT_W: DUT response.
- `care_mask`  in  OUT_W: 1 = bit compared. Must be static while `busy`.
- `busy`  out  1: sweep or drain in progress.
- `done`  out  1: one-cycle pulse at normal completion.
- `pass`  out  1: result of the last completed sweep.
- `err_cnt`  out  CNT_W: saturating mismatch count.
- `first_valid`  out  1: at least one mismatch recorded.
- `first_idx`  out  IN_W: vector index of the first mismatch.
- `first_ref`, `first_dut`  out  OUT_W: responses captured at the first mismatch.

## Operation
- States:
  - IDLE: `start` → SWEEP.
  - SWEEP: after the last vector is issued → DRAIN.
  - DRAIN: when the pipeline is empty → DONE.
  - DONE: unconditionally → IDLE.
- On entering SWEEP:
  - `err_cnt`, `first_*` and `pass` are cleared.
  - `stim` = 0, then increments by 1 per cycle up to 2^IN_W−1. No wrap: `stim` holds the last vector after SWEEP.
- Each issued vector pushes (valid, index) into a delay line of depth LAT.
- When the delayed entry is valid, compare `(y_ref ^ y_dut) & care_mask`. If the result is nonzero:
  - `err_cnt` increments, saturating at 2^CNT_W−1 with no wrap.
  - If `first_valid` = 0: capture the index, `y_ref` and `y_dut`, and set `first_valid`.
- DONE:
  - `pass` = (`err_cnt` == 0).
  - `done` = 1 for that cycle.
  - All result outputs hold until the next `start`.
- `start` while `busy` is ignored. `start` held high across DONE→IDLE launches a new sweep on the following edge.
- `abort` (any non-IDLE state):
  - Next state is IDLE and the delay line is flushed.
  - `done` is not pulsed and `pass` = 0.
  - `err_cnt` and `first_*` keep their partial values.
  - `abort` outranks `start` and the state transitions in the same cycle.
- Width rules:
  - The index is carried at IN_W bits.
  - The compare is bitwise with no sign or zero extension; both buses are exactly OUT_W.
- Reset values: `stim` 0, `busy` 0, `done` 0, `pass` 0, `err_cnt` 0, `first_valid` 0, `first_idx` 0, `first_ref` 0, `first_dut` 0; state IDLE; delay line empty.

## Timing
- `start` sampled high at edge k, with N = 2^IN_W:
  - Vector i is driven from edge k+i.
  - Its response is compared and registered at edge k+i+LAT+1.
- The last comparison is registered at edge k+N+LAT. `done` is high in the cycle after that edge, and `busy` falls at that same edge.
- `busy` rises at edge k.
- Total sweep: N+LAT+1 cycles from `start` to `done`.
- LAT = 0: DRAIN lasts zero cycles (SWEEP→DONE directly); the comparison sees `stim`'s own cycle.
- `abort` sampled at edge a: `busy` = 0 after edge a, and no comparison is registered at or after edge a.
- Reset asserted mid-sweep: all outputs go to reset values immediately and asynchronously. The block resumes in IDLE.

## Structure
- Shared package `vh_pkg`:
  - state enum (IDLE, SWEEP, DRAIN, DONE);
  - `LAT_MAX` = 15.
- Sub-module `vh_delay_line`:
  - parameterised depth LAT and payload width 1+IN_W;
  - shift register with synchronous flush;
  - LAT = 0 is a wire passthrough.
- Top module holds the FSM, stimulus counter, comparator and result registers.

## Test plan
- IN_W=4, OUT_W=4, LAT=2; `y_ref` = `y_dut` = `stim` delayed 2 cycles; `start` at edge k → `done` in the cycle after edge k+18, `pass`=1, `err_cnt`=0, `first_valid`=0.
- Same setup, `y_dut` bit0 inverted for index 5 only → `err_cnt`=1, `first_idx`=5, `first_ref`=4'h5, `first_dut`=4'h4, `pass`=0.
- Same injection with `care_mask`=4'b1110 → `pass`=1, `err_cnt`=0.
- CNT_W=3, `y_dut` = ~`y_ref` for all vectors → `err_cnt`=7 (saturated), `first_idx`=0.
- `abort` at edge k+5 → `busy`=0 after that edge, `done` never pulses, `pass`=0; `start` during the sweep ignored (`stim` sequence unbroken).
- `rst_n` low at edge k+7 (LAT=0) → all outputs 0 asynchronously; a new `start` yields a full clean sweep with `done` in the cycle after edge k'+16.
